// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: immediate-type select and the opcodes that pick it.
package fetch_queue_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_CSR = 3'b101
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/fetch_queue_imm_predecode.sv
// Opcode to immediate-type select; purely combinational, no handshake.
// Opcodes without an immediate map to I-type since decode ignores the field.
module imm_predecode
  import fetch_queue_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_type_e  imm_type_o
);

  always_comb begin
    imm_type_o = IMM_I;
    unique case (opcode_i)
      OP_STORE:        imm_type_o = IMM_S;
      OP_BRANCH:       imm_type_o = IMM_B;
      OP_JAL:          imm_type_o = IMM_J;
      OP_LUI, OP_AUIPC: imm_type_o = IMM_U;
      default:         imm_type_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// Pre-decoding instruction FIFO between fetch and decode; 1-cycle push-to-head latency.
// Ready/valid come from count only; full blocks push even if decode pops that cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 25
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [INSTR_WIDTH-1:0]   fetch_instr_i,
  input  logic [ADDR_WIDTH-1:0]    fetch_pc_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [INSTR_WIDTH-1:0]   dec_instr_o,
  output logic [ADDR_WIDTH-1:0]    dec_pc_o,
  output logic [IMM_WIDTH-1:0]     dec_imm_o,
  output logic [2:0]               dec_imm_type_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  imm_type_e              type_q  [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  imm_type_e fetch_type;
  logic      push, pop;

  imm_predecode u_predecode (
    .opcode_i   (fetch_instr_i[6:0]),
    .imm_type_o (fetch_type)
  );

  assign fetch_ready_o = (count_q != CW'(DEPTH));
  assign dec_valid_o   = (count_q != '0);
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop           = dec_valid_o && dec_ready_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head fields read as zero before the first push.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        type_q[i]  <= IMM_I;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]    <= fetch_pc_i;
      instr_q[wr_ptr_q] <= fetch_instr_i;
      type_q[wr_ptr_q]  <= fetch_type;
    end
  end

  assign dec_instr_o    = instr_q[rd_ptr_q];
  assign dec_pc_o       = pc_q[rd_ptr_q];
  assign dec_imm_o      = instr_q[rd_ptr_q][IMM_WIDTH+6:7];
  assign dec_imm_type_o = type_q[rd_ptr_q];
  assign count_o        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with hand-computed expected values.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i;
  logic [63:0] fetch_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [63:0] dec_pc_o;
  logic [24:0] dec_imm_o;
  logic [2:0]  dec_imm_type_o;
  logic [2:0]  count_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(4), .ADDR_WIDTH(64), .INSTR_WIDTH(32), .IMM_WIDTH(25)) dut (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_instr_i  (fetch_instr_i),
    .fetch_pc_i     (fetch_pc_i),
    .dec_valid_o    (dec_valid_o),
    .dec_ready_i    (dec_ready_i),
    .dec_instr_o    (dec_instr_o),
    .dec_pc_o       (dec_pc_o),
    .dec_imm_o      (dec_imm_o),
    .dec_imm_type_o (dec_imm_type_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    fetch_valid_i = 1'b1;
    fetch_instr_i = instr;
    fetch_pc_i    = pc;
  endtask

  logic [31:0] four_instr [4] = '{32'h0020A423, 32'h00000463, 32'h0080006F, 32'h123450B7};
  logic [2:0]  four_type  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

  initial begin
    arst_ni       = 1'b0;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_instr_i = '0;
    fetch_pc_i    = '0;
    dec_ready_i   = 1'b0;
    #12;
    chk("rst_ready", fetch_ready_o, 1);
    chk("rst_valid", dec_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_instr", dec_instr_o, 0);
    chk("rst_pc", dec_pc_o, 0);
    chk("rst_imm", dec_imm_o, 0);
    chk("rst_type", dec_imm_type_o, 0);
    arst_ni = 1'b1;
    step();

    // single addi push
    offer(32'h00500093, 64'h1000);
    step();
    fetch_valid_i = 1'b0;
    chk("addi_valid", dec_valid_o, 1);
    chk("addi_pc", dec_pc_o, 64'h1000);
    chk("addi_instr", dec_instr_o, 32'h00500093);
    chk("addi_imm", dec_imm_o, 25'h0A001);
    chk("addi_type", dec_imm_type_o, 3'b000);
    chk("addi_count", count_o, 1);
    dec_ready_i = 1'b1;
    step();
    dec_ready_i = 1'b0;
    chk("addi_pop_count", count_o, 0);
    chk("addi_pop_valid", dec_valid_o, 0);

    // fill with S/B/J/U, then hold a fifth push against a full queue
    for (int i = 0; i < 4; i++) begin
      offer(four_instr[i], 64'h2000 + 64'(4 * i));
      step();
    end
    chk("full_count", count_o, 4);
    chk("full_ready", fetch_ready_o, 0);
    offer(32'h00100113, 64'h3000);
    step();
    step();
    chk("full_hold_count", count_o, 4);
    chk("full_head_pc", dec_pc_o, 64'h2000);
    chk("s_imm", dec_imm_o, 25'h0004148);
    dec_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_type", i), dec_imm_type_o, four_type[i]);
      chk($sformatf("pop%0d_pc", i), dec_pc_o, 64'h2000 + 64'(4 * i));
      step();
      if (i == 0) begin
        // space freed by the pop shows up only after the edge
        chk("freed_ready", fetch_ready_o, 1);
        chk("freed_count", count_o, 3);
        fetch_valid_i = 1'b0;
      end
    end
    dec_ready_i = 1'b0;
    chk("drain_count", count_o, 0);

    // steady-state push+pop at count 2, crossing the pointer wrap
    for (int i = 0; i < 2; i++) begin
      offer(32'h00000013, 64'h100 + 64'(4 * i));
      step();
    end
    fetch_valid_i = 1'b0;
    chk("pp_start_count", count_o, 2);
    dec_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pp%0d_pc", k), dec_pc_o, 64'h100 + 64'(4 * k));
      offer(32'h00000013, 64'h108 + 64'(4 * k));
      step();
      chk($sformatf("pp%0d_count", k), count_o, 2);
    end
    dec_ready_i = 1'b0;
    chk("pp_tail_pc", dec_pc_o, 64'h128);
    offer(32'h00000013, 64'h130);
    step();
    chk("pre_flush_count", count_o, 3);

    // flush with a push offered in the same cycle
    offer(32'h00000013, 64'hDEAD0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", dec_valid_o, 0);
    chk("flush_ready", fetch_ready_o, 1);
    offer(32'h00000013, 64'h5000);
    step();
    fetch_valid_i = 1'b0;
    chk("post_flush_pc", dec_pc_o, 64'h5000);
    chk("post_flush_count", count_o, 1);

    // asynchronous reset between edges with data queued
    offer(32'h123450B7, 64'h5004);
    #2;
    arst_ni = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", dec_valid_o, 0);
    chk("arst_ready", fetch_ready_o, 1);
    chk("arst_pc", dec_pc_o, 0);
    chk("arst_instr", dec_instr_o, 0);
    fetch_valid_i = 1'b0;
    #1;
    arst_ni = 1'b1;
    step();
    chk("arst_idle_count", count_o, 0);
    offer(32'h0080006F, 64'h6000);
    step();
    fetch_valid_i = 1'b0;
    chk("arst_push_valid", dec_valid_o, 1);
    chk("arst_push_pc", dec_pc_o, 64'h6000);
    chk("arst_push_type", dec_imm_type_o, 3'b011);
    chk("arst_push_count", count_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
